// File: rtl/serial_frame_pkg.sv
// Shared definitions for the framed serial link (transmitter and receiver).
package serial_frame_pkg;

    localparam int unsigned DEF_DATA_W       = 8;
    localparam bit          DEF_PARITY_EN    = 1'b0;
    localparam int unsigned DEF_STOP_BITS    = 1;
    localparam int unsigned DEF_CLKS_PER_BIT = 4;
    localparam bit          DEF_IDLE_LEVEL   = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Number of line bits in one frame: start + data + optional parity + stops.
    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input bit          parity_en,
                                               input int unsigned stop_bits);
        return 32'd1 + data_w + 32'(parity_en) + stop_bits;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per line bit, restartable.
module serial_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end_c,
    output logic near_end_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Strobes: last cycle of the bit, and the cycle just before it.
    always_comb begin
        bit_end_c  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        near_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
    end

    // Count up, wrapping at the end of each bit; restart forces the next cycle to count 0.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || bit_end_c) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start, DATA_W bits LSB first, optional even parity, stop bits.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter bit          PARITY_EN    = DEF_PARITY_EN,
    parameter int unsigned STOP_BITS    = DEF_STOP_BITS,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit          IDLE_LEVEL   = DEF_IDLE_LEVEL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_line,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned IDX_W = $clog2(DATA_W + 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic              tx_line_q, tx_line_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic accept_c;
    logic last_stop_c;
    logic final_next_c;
    logic restart_c;
    logic bit_end_c;
    logic near_end_c;

    assign in_ready   = ready_q;
    assign tx_line    = tx_line_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart_c),
        .bit_end_c  (bit_end_c),
        .near_end_c (near_end_c)
    );

    // Next-state, datapath and registered-output lookahead.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;

        accept_c    = in_valid && ready_q;
        last_stop_c = (state_q == STOP) && (stop_idx_q == 1'(STOP_BITS - 1));
        // The next cycle is the final cycle of the final stop bit.
        final_next_c = last_stop_c && near_end_c;

        if (accept_c) begin
            shreg_d  = in_data;
            parity_d = ^in_data;
        end

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        bit_idx_d = '0;
                        state_d   = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    if (last_stop_c) begin
                        stop_idx_d = 1'b0;
                        state_d    = accept_c ? START : IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timer is held at zero while idle and restarted on every state change.
        restart_c = (state_d != state_q) || (state_q == IDLE);

        // Line level for the cycle that follows this edge.
        case (state_d)
            START:   tx_line_d = ~IDLE_LEVEL;
            DATA:    tx_line_d = shreg_d[0];
            PARITY:  tx_line_d = parity_d;
            default: tx_line_d = IDLE_LEVEL;
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) || final_next_c;
        done_d  = final_next_c;
    end

    // State and output registers; reset drives the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_line_q  <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_line_q  <= tx_line_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx over four parameter sets.
module tb_serial_frame_tx;

    localparam int NI = 4;
    localparam int P_DW   [NI] = '{8, 8, 8, 5};
    localparam int P_PAR  [NI] = '{0, 1, 0, 1};
    localparam int P_SB   [NI] = '{1, 1, 2, 2};
    localparam int P_C    [NI] = '{4, 4, 3, 2};
    localparam int P_IDLE [NI] = '{1, 1, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid   [NI];
    logic [31:0] in_data    [NI];
    logic        in_ready   [NI];
    logic        tx_line    [NI];
    logic        busy       [NI];
    logic        frame_done [NI];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .PARITY_EN(1'b0), .STOP_BITS(1), .CLKS_PER_BIT(4), .IDLE_LEVEL(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0][7:0]),
        .tx_line(tx_line[0]), .busy(busy[0]), .frame_done(frame_done[0]));
    serial_frame_tx #(.DATA_W(8), .PARITY_EN(1'b1), .STOP_BITS(1), .CLKS_PER_BIT(4), .IDLE_LEVEL(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1][7:0]),
        .tx_line(tx_line[1]), .busy(busy[1]), .frame_done(frame_done[1]));
    serial_frame_tx #(.DATA_W(8), .PARITY_EN(1'b0), .STOP_BITS(2), .CLKS_PER_BIT(3), .IDLE_LEVEL(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2][7:0]),
        .tx_line(tx_line[2]), .busy(busy[2]), .frame_done(frame_done[2]));
    serial_frame_tx #(.DATA_W(5), .PARITY_EN(1'b1), .STOP_BITS(2), .CLKS_PER_BIT(2), .IDLE_LEVEL(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3][4:0]),
        .tx_line(tx_line[3]), .busy(busy[3]), .frame_done(frame_done[3]));

    typedef struct {
        int          k;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nwords;
        bit          toggle;
        int          exp_len;   // cycle (after accept) of the first frame_done
        int          exp_par;   // expected parity bit on the line, -1 if none
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Expected line bits of one frame, each repeated for its bit period.
    task automatic add_frame(input int k, input logic [31:0] w, inout logic q[$]);
        logic p;
        p = 1'b0;
        for (int r = 0; r < P_C[k]; r++) q.push_back(~P_IDLE[k][0]);
        for (int i = 0; i < P_DW[k]; i++) begin
            p = p ^ w[i];
            for (int r = 0; r < P_C[k]; r++) q.push_back(w[i]);
        end
        if (P_PAR[k] != 0)
            for (int r = 0; r < P_C[k]; r++) q.push_back(p);
        for (int s = 0; s < P_SB[k] * P_C[k]; s++) q.push_back(P_IDLE[k][0]);
    endtask

    // Send one word (or two held back-to-back) and check every cycle of the stream.
    task automatic run_frames(input int k, input logic [31:0] w0, input logic [31:0] w1,
                              input int nwords, input bit toggle,
                              output int first_done, output logic par_smp);
        logic       q[$];
        int         len, total;
        logic [3:0] act, exp;
        q = {};
        add_frame(k, w0, q);
        if (nwords == 2) add_frame(k, w1, q);
        total = q.size();
        len   = total / nwords;
        first_done = -1;
        par_smp    = 1'b0;

        @(negedge clk);
        chk($sformatf("inst%0d ready_before_accept", k), 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = w0;
        @(posedge clk);
        for (int n = 1; n <= total; n++) begin
            @(negedge clk);
            act = {tx_line[k], busy[k], frame_done[k], in_ready[k]};
            exp = {q[n-1], 1'b1, (n % len) == 0, (n % len) == 0};
            chk($sformatf("inst%0d cyc%0d {line,busy,done,ready}", k, n), 32'(act), 32'(exp));
            if (frame_done[k] && first_done < 0) first_done = n;
            if (n == (1 + P_DW[k]) * P_C[k] + 1) par_smp = tx_line[k];
            if (nwords == 2 && n <= len) begin
                in_valid[k] = 1'b1;
                in_data[k]  = w1;
            end else begin
                in_valid[k] = 1'b0;
                if (toggle) in_data[k] = $urandom;
            end
        end
        @(negedge clk);
        act = {tx_line[k], busy[k], frame_done[k], in_ready[k]};
        chk($sformatf("inst%0d after_frame", k), 32'(act), 32'({P_IDLE[k][0], 3'b001}));
    endtask

    vec_t        tbl[8];
    int          fd;
    logic        ps;
    logic [31:0] mask, w0, w1;
    int          k, nw, exp_len;

    initial begin
        tbl[0] = '{0, 32'hA5, 32'h00, 1, 1'b0, 40, -1};
        tbl[1] = '{1, 32'h07, 32'h00, 1, 1'b0, 44,  1};
        tbl[2] = '{1, 32'h03, 32'h00, 1, 1'b0, 44,  0};
        tbl[3] = '{0, 32'h55, 32'hF0, 2, 1'b0, 40, -1};
        tbl[4] = '{2, 32'h00, 32'h00, 1, 1'b0, 33, -1};
        tbl[5] = '{0, 32'hC3, 32'h00, 1, 1'b1, 40, -1};
        tbl[6] = '{3, 32'h1A, 32'h00, 1, 1'b1, 18,  1};
        tbl[7] = '{3, 32'h0F, 32'h11, 2, 1'b0, 18,  0};

        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("inst%0d in_reset {line,busy,done}", i),
                32'({tx_line[i], busy[i], frame_done[i]}), 32'({P_IDLE[i][0], 2'b00}));
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("inst%0d after_reset {line,busy,done,ready}", i),
                32'({tx_line[i], busy[i], frame_done[i], in_ready[i]}), 32'({P_IDLE[i][0], 3'b001}));

        // Directed table.
        for (int t = 0; t < 8; t++) begin
            run_frames(tbl[t].k, tbl[t].w0, tbl[t].w1, tbl[t].nwords, tbl[t].toggle, fd, ps);
            chk($sformatf("vec%0d first_done_cycle", t), 32'(fd), 32'(tbl[t].exp_len));
            if (tbl[t].exp_par >= 0)
                chk($sformatf("vec%0d parity_bit", t), 32'(ps), 32'(tbl[t].exp_par));
        end

        // Reset in the middle of data bit 3 (C3: bit3 = 0).
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'hC3;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("midframe data_bit3", 32'(tx_line[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset {line,busy,done}", 32'({tx_line[0], busy[0], frame_done[0]}), 32'b100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset {line,busy,done,ready}",
            32'({tx_line[0], busy[0], frame_done[0], in_ready[0]}), 32'b1001);
        run_frames(0, 32'h81, 32'h00, 1, 1'b0, fd, ps);
        chk("post_reset 81 first_done_cycle", 32'(fd), 32'd40);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            k    = $urandom_range(0, NI - 1);
            mask = (32'd1 << P_DW[k]) - 32'd1;
            w0   = $urandom & mask;
            w1   = $urandom & mask;
            nw   = $urandom_range(1, 2);
            exp_len = (1 + P_DW[k] + P_PAR[k] + P_SB[k]) * P_C[k];
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frames(k, w0, w1, nw, nw == 1 && $urandom_range(0, 1) == 1, fd, ps);
            chk($sformatf("rand%0d inst%0d first_done_cycle", it, k), 32'(fd), 32'(exp_len));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
